// File: rtl/program_memory_pkg.sv
// Shared constants and types for the program memory.
// The instruction word type is also used by the CPU datapath.
package program_memory_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] instr_t;

endpackage

// File: rtl/program_memory_ctrl.sv
// Fill-level control for the program memory.
// Owns count/write pointer, full flag, load_err and clear/load priority.
module program_memory_ctrl
    import program_memory_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic                       clear,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       load_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    // No wrap-around: the pointer is the fill level itself.
    assign full   = (count == DEPTH_C);
    assign wr_ptr = count[AW-1:0];
    assign wr_en  = load && !clear && !full;

    // Fill level: clear wins over load, rejected loads leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + ONE;
        end
    end

    // Overflow pulse, one cycle after a load that found the store full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !clear && full;
        end
    end

endmodule

// File: rtl/program_memory.sv
// Sequentially loaded instruction store with registered indexed fetch.
// Entries beyond the fill level are kept at zero.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [WIDTH-1:0]           new_instruction,
    input  logic                       clear,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   index,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       load_err,
    output logic                       rd_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    wr_ptr;
    logic             in_range;

    program_memory_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .count    (count),
        .full     (full),
        .load_err (load_err)
    );

    // Uses the pre-edge count, so a same-cycle load is not yet visible.
    assign in_range = ({1'b0, index} < count);

    // Storage: wiped on reset and clear, appended at the write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= new_instruction;
        end
    end

    // Registered fetch: out holds when idle, strobes valid/error per request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            rd_err    <= 1'b0;
        end else if (rd_en) begin
            out_valid <= 1'b1;
            if (in_range) begin
                out    <= mem[index];
                rd_err <= 1'b0;
            end else begin
                out    <= '0;
                rd_err <= 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            rd_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Directed-vector bench for program_memory (WIDTH 12, DEPTH 8).
// Each vector is applied before an edge and checked just after it.
module tb_program_memory;
    import program_memory_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         load;
    instr_t       new_instruction;
    logic         clear;
    logic         rd_en;
    logic [2:0]   index;
    instr_t       out;
    logic         out_valid;
    logic [3:0]   count;
    logic         full;
    logic         load_err;
    logic         rd_err;

    int passed = 0;
    int total  = 0;

    program_memory #(
        .WIDTH(12),
        .DEPTH(8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load            (load),
        .new_instruction (new_instruction),
        .clear           (clear),
        .rd_en           (rd_en),
        .index           (index),
        .out             (out),
        .out_valid       (out_valid),
        .count           (count),
        .full            (full),
        .load_err        (load_err),
        .rd_err          (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ld;
        logic [11:0] din;
        logic       clr;
        logic       rd;
        logic [2:0] idx;
        logic [11:0] e_out;
        logic       e_valid;
        logic       e_rderr;
        logic       e_lderr;
        logic [3:0] e_count;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic ld, logic [11:0] din,
                                logic clr, logic rd, logic [2:0] idx,
                                logic [11:0] eo, logic ev, logic er,
                                logic el, logic [3:0] ec, logic ef);
        vec_t v;
        v.name = nm; v.ld = ld; v.din = din; v.clr = clr;
        v.rd = rd; v.idx = idx; v.e_out = eo; v.e_valid = ev;
        v.e_rderr = er; v.e_lderr = el; v.e_count = ec; v.e_full = ef;
        return v;
    endfunction

    task automatic check(string nm, logic [11:0] eo, logic ev, logic er,
                         logic el, logic [3:0] ec, logic ef);
        logic [19:0] got, exp;
        got = {out, out_valid, rd_err, load_err, count, full};
        exp = {eo, ev, er, el, ec, ef};
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got out=%h v=%b rerr=%b lerr=%b cnt=%0d full=%b, want out=%h v=%b rerr=%b lerr=%b cnt=%0d full=%b",
                     nm, out, out_valid, rd_err, load_err, count, full,
                     eo, ev, er, el, ec, ef);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        load = v.ld; new_instruction = v.din; clear = v.clr;
        rd_en = v.rd; index = v.idx;
        @(posedge clk);
        #1;
        check(v.name, v.e_out, v.e_valid, v.e_rderr, v.e_lderr,
              v.e_count, v.e_full);
    endtask

    task automatic idle();
        @(negedge clk);
        load = 0; clear = 0; rd_en = 0; index = 0; new_instruction = 0;
    endtask

    initial begin
        reset_n = 0; load = 0; new_instruction = 0; clear = 0;
        rd_en = 0; index = 0;

        // empty store: every fetch errors
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("empty_fetch", 0, 0, 0, 1, 3'(i),
                              0, 1, 1, 0, 0, 0));
        // fill 0x001..0x008, full on the eighth
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("fill", 1, 12'(i + 1), 0, 0, 0,
                              0, 0, 0, 0, 4'(i + 1), i == 7));
        // read back
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("readback", 0, 0, 0, 1, 3'(i),
                              12'(i + 1), 1, 0, 0, 8, 1));
        // overflow, then previous content intact
        vecs.push_back(mk("overflow", 1, 12'hABC, 0, 0, 0,
                          12'h008, 0, 0, 1, 8, 1));
        vecs.push_back(mk("post_ovf", 0, 0, 0, 1, 0,
                          12'h001, 1, 0, 0, 8, 1));
        // clear beats load, no load_err
        vecs.push_back(mk("clear_load", 1, 12'h555, 1, 0, 0,
                          12'h001, 0, 0, 0, 0, 0));
        vecs.push_back(mk("after_clear", 0, 0, 0, 1, 0,
                          12'h000, 1, 1, 0, 0, 0));
        // three loads, then fetch racing the fourth load
        vecs.push_back(mk("ld111", 1, 12'h111, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("ld222", 1, 12'h222, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk("ld333", 1, 12'h333, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk("race_ld444", 1, 12'h444, 0, 1, 3,
                          12'h000, 1, 1, 0, 4, 0));
        vecs.push_back(mk("fetch3", 0, 0, 0, 1, 3,
                          12'h444, 1, 0, 0, 4, 0));
        vecs.push_back(mk("idle_hold", 0, 0, 0, 0, 0,
                          12'h444, 0, 0, 0, 4, 0));
        // fetch racing clear sees pre-clear word
        vecs.push_back(mk("race_clear", 0, 0, 1, 1, 1,
                          12'h222, 1, 0, 0, 0, 0));
        vecs.push_back(mk("post_clear1", 0, 0, 0, 1, 1,
                          12'h000, 1, 1, 0, 0, 0));
        // stale entry beyond count reads zero after partial reload
        vecs.push_back(mk("ld_a", 1, 12'hA01, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("beyond", 0, 0, 0, 1, 1,
                          12'h000, 1, 1, 0, 1, 0));
        vecs.push_back(mk("fetch0", 0, 0, 0, 1, 0,
                          12'hA01, 1, 0, 0, 1, 0));

        #12;
        check("reset_state", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1;

        foreach (vecs[i]) apply(vecs[i]);

        // reset dropped between edges with a result just delivered
        apply(mk("ld_b", 1, 12'hB02, 0, 0, 0, 12'hA01, 0, 0, 0, 2, 0));
        apply(mk("ld_c", 1, 12'hC03, 0, 0, 0, 12'hA01, 0, 0, 0, 3, 0));
        apply(mk("ld_d", 1, 12'hD04, 0, 0, 0, 12'hA01, 0, 0, 0, 4, 0));
        apply(mk("pre_rst_fetch", 0, 0, 0, 1, 2,
                 12'hC03, 1, 0, 0, 4, 0));
        #1;
        reset_n = 0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 0, 0, 0, 0, 0);
        idle();
        reset_n = 1;
        @(posedge clk);
        #1;
        check("no_stale_valid", 0, 0, 0, 0, 0, 0);
        apply(mk("post_rst_fetch", 0, 0, 0, 1, 0,
                 12'h000, 1, 1, 0, 0, 0));
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
